pipe_ctrl_reg: RTL and testbench

PIPE_CTRL_REG -- requirements
Module: pipe_ctrl_reg

---
 rtl/pipe_ctrl_reg.sv | 91 +++++++++
 tb/tb_pipe_ctrl_reg.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_reg.sv
// Stall/flush-aware control-bundle pipeline with optional statistics counters.
// Define PIPE_CTRL_STATS_EN to build stall_cnt/bubble_cnt; otherwise they read 0.
module pipe_ctrl_reg #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic [STAGES-1:0]       flush,
  input  logic                    valid_d,
  input  logic [WIDTH-1:0]        ctrl_d,
  output logic [WIDTH-1:0]        ctrl_e,
  output logic                    valid_e,
  output logic [STAGES-1:0]       stage_valid,
  output logic [STAGES*WIDTH-1:0] ctrl_all,
  input  logic                    stats_clr,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        bubble_cnt
);

  logic [WIDTH-1:0] ctrl_reg  [STAGES];
  logic             valid_reg [STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [WIDTH-1:0] src_ctrl;
      logic             src_valid;

      if (gi == 0) begin : g_head
        // Invalid input is masked so a bubble is always all-zero
        assign src_ctrl  = valid_d ? ctrl_d : '0;
        assign src_valid = valid_d;
      end else begin : g_body
        assign src_ctrl  = ctrl_reg[gi-1];
        assign src_valid = valid_reg[gi-1];
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          ctrl_reg[gi]  <= '0;
          valid_reg[gi] <= 1'b0;
        end else if (flush[gi]) begin
          ctrl_reg[gi]  <= '0;
          valid_reg[gi] <= 1'b0;
        end else if (!stall) begin
          ctrl_reg[gi]  <= src_ctrl;
          valid_reg[gi] <= src_valid;
        end
      end

      assign ctrl_all[gi*WIDTH +: WIDTH] = ctrl_reg[gi];
      assign stage_valid[gi]             = valid_reg[gi];
    end
  endgenerate

  assign ctrl_e  = ctrl_reg[STAGES-1];
  assign valid_e = valid_reg[STAGES-1];

`ifdef PIPE_CTRL_STATS_EN
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] bubble_cnt_reg;

  // Both counters saturate at all-ones; clear wins over increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_reg  <= '0;
      bubble_cnt_reg <= '0;
    end else if (stats_clr) begin
      stall_cnt_reg  <= '0;
      bubble_cnt_reg <= '0;
    end else begin
      if (stall && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (!valid_e && (bubble_cnt_reg != '1))
        bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt  = stall_cnt_reg;
  assign bubble_cnt = bubble_cnt_reg;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign stall_cnt        = '0;
  assign bubble_cnt       = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_reg.sv
// Directed self-checking bench for pipe_ctrl_reg (STAGES=2, WIDTH=16, CNT_W=4).
module tb_pipe_ctrl_reg;

  localparam int WIDTH  = 16;
  localparam int STAGES = 2;
  localparam int CNT_W  = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    stall;
  logic [STAGES-1:0]       flush;
  logic                    valid_d;
  logic [WIDTH-1:0]        ctrl_d;
  logic [WIDTH-1:0]        ctrl_e;
  logic                    valid_e;
  logic [STAGES-1:0]       stage_valid;
  logic [STAGES*WIDTH-1:0] ctrl_all;
  logic                    stats_clr;
  logic [CNT_W-1:0]        stall_cnt;
  logic [CNT_W-1:0]        bubble_cnt;

  int checks = 0;
  int errors = 0;

  pipe_ctrl_reg #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_d(valid_d), .ctrl_d(ctrl_d), .ctrl_e(ctrl_e), .valid_e(valid_e),
    .stage_valid(stage_valid), .ctrl_all(ctrl_all), .stats_clr(stats_clr),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pipe(input string tag, input logic [15:0] e, input logic v,
                            input logic [1:0] sv, input logic [31:0] all);
    check({tag, ".ctrl_e"}, 64'(ctrl_e), 64'(e));
    check({tag, ".valid_e"}, 64'(valid_e), 64'(v));
    check({tag, ".stage_valid"}, 64'(stage_valid), 64'(sv));
    check({tag, ".ctrl_all"}, 64'(ctrl_all), 64'(all));
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = '0; valid_d = 1'b0;
    ctrl_d = '0; stats_clr = 1'b0;
    #12;
    check_pipe("reset", 16'h0, 1'b0, 2'b00, 32'h0);
    check("reset.stall_cnt", 64'(stall_cnt), 64'h0);
    check("reset.bubble_cnt", 64'(bubble_cnt), 64'h0);
    @(negedge clk); reset = 1'b1;

    // Single bundle, latency of two edges, masked when invalid
    #1; ctrl_d = 16'hA5A5; valid_d = 1'b1;
    step(); ctrl_d = 16'hFFFF; valid_d = 1'b0;
    check_pipe("lat1", 16'h0, 1'b0, 2'b01, 32'h0000_A5A5);
    step();
    check_pipe("lat2", 16'hA5A5, 1'b1, 2'b10, 32'hA5A5_0000);
    step();
    check_pipe("lat3", 16'h0, 1'b0, 2'b00, 32'h0);

    // Clear stats, then stream 1,2,3 with a stall on the second edge
    stats_clr = 1'b1; step(); stats_clr = 1'b0;
    ctrl_d = 16'h1; valid_d = 1'b1;
    step(); check_pipe("strm_a", 16'h0, 1'b0, 2'b01, 32'h0000_0001);
    ctrl_d = 16'h2; stall = 1'b1;
    step(); check_pipe("strm_b", 16'h0, 1'b0, 2'b01, 32'h0000_0001);
    stall = 1'b0;
    step(); check_pipe("strm_c", 16'h1, 1'b1, 2'b11, 32'h0001_0002);
    ctrl_d = 16'h3;
    step(); check_pipe("strm_d", 16'h2, 1'b1, 2'b11, 32'h0002_0003);
    valid_d = 1'b0; ctrl_d = 16'h0;
    step(); check_pipe("strm_e", 16'h3, 1'b1, 2'b10, 32'h0003_0000);
    step(); check_pipe("strm_f", 16'h0, 1'b0, 2'b00, 32'h0);
`ifdef PIPE_CTRL_STATS_EN
    check("strm.stall_cnt", 64'(stall_cnt), 64'h1);
    check("strm.bubble_cnt", 64'(bubble_cnt), 64'h3);
`else
    check("strm.stall_cnt", 64'(stall_cnt), 64'h0);
    check("strm.bubble_cnt", 64'(bubble_cnt), 64'h0);
`endif

    // Flush of last stage overrides stall; stage 0 held
    ctrl_d = 16'h7; valid_d = 1'b1; step();
    ctrl_d = 16'h9; step();
    check_pipe("fl1_pre", 16'h7, 1'b1, 2'b11, 32'h0007_0009);
    stall = 1'b1; flush = 2'b10; step();
    check_pipe("fl1", 16'h0, 1'b0, 2'b01, 32'h0000_0009);

    // Flush of stage 0 while stage 1 still advances
    stall = 1'b0; flush = 2'b00; ctrl_d = 16'h3; step();
    check_pipe("fl0_pre", 16'h9, 1'b1, 2'b11, 32'h0009_0003);
    flush = 2'b01; ctrl_d = 16'h5; step();
    check_pipe("fl0", 16'h3, 1'b1, 2'b10, 32'h0003_0000);
    flush = 2'b00;

    // Asynchronous reset mid-cycle with a full pipeline
    ctrl_d = 16'h11; step();
    ctrl_d = 16'h22; step();
    check_pipe("full", 16'h11, 1'b1, 2'b11, 32'h0011_0022);
    #2 reset = 1'b0;
    #1 check_pipe("areset", 16'h0, 1'b0, 2'b00, 32'h0);
    check("areset.stall", 64'(stall_cnt), 64'h0);
    check("areset.bubble", 64'(bubble_cnt), 64'h0);
    step();
    check_pipe("rst_hold", 16'h0, 1'b0, 2'b00, 32'h0);
    @(negedge clk); reset = 1'b1; ctrl_d = 16'h44;
    step();
    check_pipe("rst_rel", 16'h0, 1'b0, 2'b01, 32'h0000_0044);

    // Saturating stall counter, then clear (also under simultaneous stall)
    stall = 1'b1; valid_d = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check_pipe("sat_hold", 16'h0, 1'b0, 2'b01, 32'h0000_0044);
`ifdef PIPE_CTRL_STATS_EN
    check("sat.stall_cnt", 64'(stall_cnt), 64'hF);
    check("sat.bubble_cnt", 64'(bubble_cnt), 64'hF);
`else
    check("sat.stall_cnt", 64'(stall_cnt), 64'h0);
    check("sat.bubble_cnt", 64'(bubble_cnt), 64'h0);
`endif
    stats_clr = 1'b1; step();
    check("clr.stall_cnt", 64'(stall_cnt), 64'h0);
    check("clr.bubble_cnt", 64'(bubble_cnt), 64'h0);
    stats_clr = 1'b0; step();
`ifdef PIPE_CTRL_STATS_EN
    check("post.stall_cnt", 64'(stall_cnt), 64'h1);
`else
    check("post.stall_cnt", 64'(stall_cnt), 64'h0);
`endif
    stall = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
